pulse_stretcher: RTL and testbench

//  Inverse of the rising-edge pulse generator. Converts single-cycle request pulses into

---
 rtl/pulse_pkg.sv | 22 ++
 rtl/pulse_stretcher.sv | 115 +++++++++++
 tb/tb_pulse_stretcher.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared types and default sizing for the pulse stretcher.
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_GAP
    } stretch_state_t;

    localparam int DEF_HIGH_CYCLES = 4;
    localparam int DEF_GAP_CYCLES  = 1;
    localparam int DEF_MAX_PENDING = 3;

    // The down-counter only ever holds (cycles - 1), so clog2 of the larger phase
    // length is enough. It never collapses below one bit.
    function automatic int cnt_width(input int high_cycles, input int gap_cycles);
        int longest;
        longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
        return (longest <= 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Turns single-cycle request strobes into fixed-width level bursts
// (HIGH_CYCLES high, then GAP_CYCLES low). Strobes that arrive during a burst
// are queued in a saturating counter and served back to back.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | nothing in service, level_out low
//  HIGH    | burst in progress, level_out high, counter counts down
//  GAP     | mandatory low gap after a burst; its last cycle may restart
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic              clr_overflow,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int CNT_W = cnt_width(HIGH_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

    stretch_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_d;
    logic              ovf_set;
    logic              ovf_d;
    logic              cnt_done;

    assign cnt_done = (cnt_q == '0);

    // State, counter and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            level_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending   <= pend_d;
            overflow  <= ovf_d;
            level_out <= (state_d == ST_HIGH);
            busy      <= (state_d != ST_IDLE);
        end
    end

    // Next state, counter reload/decrement, queue bookkeeping and sticky overflow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pending;
        ovf_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (cnt_done) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (pulse_in) begin
                    if (pending == PEND_MAX) ovf_set = 1'b1;
                    else                     pend_d  = pending + PEND_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_done) begin
                    // Restart point: a live strobe is served directly, otherwise one
                    // queued request is consumed. Nothing can overflow here.
                    if (pulse_in || (pending != '0)) begin
                        state_d = ST_HIGH;
                        cnt_d   = HIGH_LOAD;
                        if (!pulse_in) pend_d = pending - PEND_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (pulse_in) begin
                        if (pending == PEND_MAX) ovf_set = 1'b1;
                        else                     pend_d  = pending + PEND_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        ovf_d = (overflow & ~clr_overflow) | ovf_set;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HIGH=4, GAP=1, MAX_PENDING=3.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       pulse_in;
    logic       clr_overflow;
    logic       level_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    pulse_stretcher #(
        .HIGH_CYCLES(4),
        .GAP_CYCLES (1),
        .MAX_PENDING(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse_in),
        .clr_overflow(clr_overflow),
        .level_out   (level_out),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int lvl, input int bsy,
                           input int pend, input int ovf);
        chk({tag, ".level"},    int'(level_out), lvl);
        chk({tag, ".busy"},     int'(busy),      bsy);
        chk({tag, ".pending"},  int'(pending),   pend);
        chk({tag, ".overflow"}, int'(overflow),  ovf);
    endtask

    // Inputs are set between edges, the edge samples them, outputs are read 1 ns later.
    task automatic tick(input logic p, input logic c);
        pulse_in     = p;
        clr_overflow = c;
        @(posedge clk);
        #1;
        pulse_in     = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic do_reset();
        pulse_in     = 1'b0;
        clr_overflow = 1'b0;
        rst          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int rises;
        logic prev;
        int exp_lvl, exp_bsy, exp_pend;

        // Reset state
        do_reset();
        chk_all("reset", 0, 0, 0, 0);

        // 1: single pulse
        tick(1'b1, 1'b0);
        chk_all("t1.E0", 1, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, 1'b0);
            chk_all($sformatf("t1.E%0d", k), 1, 1, 0, 0);
        end
        tick(1'b0, 1'b0);
        chk_all("t1.E4", 0, 1, 0, 0);
        tick(1'b0, 1'b0);
        chk_all("t1.E5", 0, 0, 0, 0);

        // 2: pulses at E0,E1,E2 -> three bursts, busy 15 cycles
        do_reset();
        for (int k = 0; k < 18; k++) begin
            tick(k <= 2, 1'b0);
            exp_lvl  = (k < 15 && (k % 5) != 4) ? 1 : 0;
            exp_bsy  = (k < 15) ? 1 : 0;
            exp_pend = (k == 0) ? 0 : (k == 1) ? 1 : (k <= 4) ? 2 : (k <= 9) ? 1 : 0;
            chk_all($sformatf("t2.E%0d", k), exp_lvl, exp_bsy, exp_pend, 0);
        end

        // 3: pulses at E0..E4 -> saturation, overflow, exactly four bursts
        do_reset();
        rises = 0;
        prev  = 1'b0;
        for (int k = 0; k < 26; k++) begin
            tick(k <= 4, 1'b0);
            exp_lvl  = (k < 20 && (k % 5) != 4) ? 1 : 0;
            exp_bsy  = (k < 20) ? 1 : 0;
            exp_pend = (k <= 3) ? k : (k <= 4) ? 3 : (k <= 9) ? 2 : (k <= 14) ? 1 : 0;
            chk_all($sformatf("t3.E%0d", k), exp_lvl, exp_bsy, exp_pend, (k >= 4) ? 1 : 0);
            if (level_out && !prev) rises++;
            prev = level_out;
        end
        chk("t3.bursts", rises, 4);

        // 4: pulse on last gap cycle with empty queue -> immediate restart
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick((k == 0) || (k == 5), 1'b0);
            exp_lvl = (k < 10 && (k % 5) != 4) ? 1 : 0;
            exp_bsy = (k < 10) ? 1 : 0;
            chk_all($sformatf("t4.E%0d", k), exp_lvl, exp_bsy, 0, 0);
        end

        // 5: asynchronous reset mid-HIGH with two queued pulses
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk_all("t5.pre", 1, 1, 2, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("t5.async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        rises = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0);
            if (level_out || busy) rises++;
        end
        chk("t5.no_bursts", rises, 0);
        chk_all("t5.post", 0, 0, 0, 0);

        // 6: set beats clear; lone clear clears
        do_reset();
        for (int k = 0; k <= 4; k++) tick(1'b1, 1'b0);
        chk_all("t6.E4", 0, 1, 3, 1);
        tick(1'b1, 1'b0);
        chk_all("t6.E5", 1, 1, 3, 1);
        tick(1'b1, 1'b1);
        chk_all("t6.E6", 1, 1, 3, 1);
        tick(1'b0, 1'b1);
        chk_all("t6.E7", 1, 1, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
